// File: rtl/sha256_bus_master.sv
// Bus initiator for the SHA-256 register-mapped core: writes a 512-bit block, starts init/next, polls STATUS, reads the digest.
// Optional build macro SHA256_BUS_MASTER_ID_CHECK_EN adds a one-time NAME0/NAME1 check before the first block after reset.
module sha256_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic              blk_first,
    input  logic [511:0]      blk_data,
    output logic [255:0]      digest,
    output logic              digest_valid,
    output logic              busy,
    output logic              err,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    localparam int            PW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(TIMEOUT_CYCLES);

`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
    localparam logic [31:0] NAME0 = 32'h73686132;
    localparam logic [31:0] NAME1 = 32'h2d323536;

    typedef enum logic [2:0] {
        IDLE, ID_CHK, WR_BLK, WR_CTRL, POLL_LO, POLL_HI, RD_DIG, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, WR_BLK, WR_CTRL, POLL_LO, POLL_HI, RD_DIG, DONE
    } state_t;
`endif

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [PW-1:0] poll_cnt, poll_n, poll_inc;
    logic [511:0]  blk_q;
    logic          first_q;
    logic [223:0]  shadow;
    logic          accept;
    logic          set_err;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
    logic          id_ok;
    logic          id_pass;
`endif

    // Saturating poll count; hitting POLL_MAX in either poll phase is a timeout.
    always_comb begin
        poll_inc = (poll_cnt == POLL_MAX) ? POLL_MAX : poll_cnt + 1'b1;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        poll_n  = poll_cnt;
        accept  = 1'b0;
        set_err = 1'b0;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
        id_pass = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (blk_valid) begin
                    accept = 1'b1;
                    cnt_n  = 4'd0;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
                    state_n = id_ok ? WR_BLK : ID_CHK;
`else
                    state_n = WR_BLK;
`endif
                end
            end
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
            ID_CHK: begin
                if (read_data != (cnt[0] ? NAME1 : NAME0)) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (cnt[0]) begin
                    id_pass = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = WR_BLK;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
`endif
            WR_BLK: begin
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_n = WR_CTRL;
                    cnt_n   = 4'd0;
                end
            end
            WR_CTRL: begin
                state_n = POLL_LO;
                poll_n  = '0;
            end
            POLL_LO: begin
                if (!read_data[0]) begin
                    state_n = POLL_HI;
                    poll_n  = '0;
                end else if (poll_inc == POLL_MAX) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else begin
                    poll_n = poll_inc;
                end
            end
            POLL_HI: begin
                if (read_data[1:0] == 2'b11) begin
                    state_n = RD_DIG;
                    cnt_n   = 4'd0;
                end else if (poll_inc == POLL_MAX) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else begin
                    poll_n = poll_inc;
                end
            end
            RD_DIG: begin
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus signals decode only from registered state, counter and latched block.
    always_comb begin
        cs         = 1'b0;
        we         = 1'b0;
        address    = '0;
        write_data = '0;
        case (state)
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
            ID_CHK: begin
                cs      = 1'b1;
                address = ADDR_W'(cnt);
            end
`endif
            WR_BLK: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_W'({4'h1, cnt});
                write_data = blk_q[{~cnt, 5'd0} +: 32];
            end
            WR_CTRL: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_W'(8'h08);
                write_data = first_q ? 32'h1 : 32'h2;
            end
            POLL_LO, POLL_HI: begin
                cs      = 1'b1;
                address = ADDR_W'(8'h09);
            end
            RD_DIG: begin
                cs      = 1'b1;
                address = ADDR_W'({5'b00100, cnt[2:0]});
            end
            default: ;
        endcase
    end

    assign blk_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign digest_valid = (state == DONE);

    // The digest register loads only on the final digest read, so it is stable for the DONE pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            poll_cnt <= '0;
            blk_q    <= '0;
            first_q  <= 1'b0;
            shadow   <= '0;
            digest   <= '0;
            err      <= 1'b0;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
            id_ok    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            poll_cnt <= poll_n;
            if (accept) begin
                blk_q   <= blk_data;
                first_q <= blk_first;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (state == RD_DIG) begin
                shadow <= {shadow[191:0], read_data};
                if (cnt == 4'd7) begin
                    digest <= {shadow, read_data};
                end
            end
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
            if (id_pass) begin
                id_ok <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sha256_bus_master.sv
// Self-checking bench for sha256_bus_master: behavioural SHA-256 responder stub plus a reference compression model.
// Define SHA256_BUS_MASTER_ID_CHECK_EN for both files to exercise the NAME check path.
module tb_sha256_bus_master;

    localparam int TO    = 16;
    localparam int LIMIT = 300;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] ABC_DIGEST  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] NIST2_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic [511:0] blk_data;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         err;
    logic         cs;
    logic         we;
    logic [7:0]   address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_bus_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_first(blk_first), .blk_data(blk_data),
        .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err),
        .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256Compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Responder stub: block/CTRL registers, STATUS busy for a random number of cycles after a start.
    logic [31:0]  stub_blk [16];
    logic [255:0] stub_h = '0;
    int           stub_busy = 0;
    logic         stub_dvalid = 1'b0;
    int           last_b = 0;
    bit           hold_zero = 1'b0;
    logic [31:0]  name0 = 32'h73686132;

    always @(posedge clk) begin : stub
        logic [511:0] sb;
        int           nb;
        if (reset) begin
            stub_busy   <= 0;
            stub_dvalid <= 1'b0;
        end else begin
            if (stub_busy > 0) stub_busy <= stub_busy - 1;
            if (cs && we) begin
                if (address[7:4] == 4'h1) begin
                    stub_blk[address[3:0]] <= write_data;
                end else if (address == 8'h08 && write_data[1:0] != 2'b00) begin
                    for (int i = 0; i < 16; i++) sb[511 - 32*i -: 32] = stub_blk[i];
                    nb = $urandom_range(2, 8);
                    stub_h      <= sha256Compress(write_data[0] ? IV : stub_h, sb);
                    stub_busy   <= nb;
                    last_b      <= nb;
                    stub_dvalid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (cs && !we) begin
            if (address == 8'h00)      read_data = name0;
            else if (address == 8'h01) read_data = 32'h2d323536;
            else if (address == 8'h09) read_data = (hold_zero || stub_busy != 0) ? 32'h0 : {30'b0, stub_dvalid, 1'b1};
            else if (address[7:3] == 5'b00100) read_data = stub_h[(7 - int'(address[2:0])) * 32 +: 32];
        end
    end

    int          cyc = 0;
    int          dv_count = 0;
    logic [39:0] wr_q [$];
    logic [7:0]  rd_q [$];

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (cs && we)  wr_q.push_back({address, write_data});
            if (cs && !we) rd_q.push_back(address);
            if (digest_valid) dv_count++;
        end
    end

    logic [255:0] model_h = '0;
    bit           err_model = 1'b0;
    bit           id_pending = 1'b0;
    int           acc_cyc = 0;
    int           res_lat = 0;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic failBound(input string tag);
        checks++;
        failures++;
        $error("[TB] FAIL %s wait bound expired observed=timeout expected=event", tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        blk_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        err_model = 1'b0;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
        id_pending = 1'b1;
`else
        id_pending = 1'b0;
`endif
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (!digest_valid && !blk_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) failBound(tag);
        res_lat = cyc - acc_cyc;
    endtask

    task automatic applyStimulus(input logic [511:0] blk, input logic first, input bit hold);
        int n = 0;
        wr_q.delete();
        rd_q.delete();
        dv_count = 0;
        @(negedge clk);
        blk_data  = blk;
        blk_first = first;
        blk_valid = 1'b1;
        while (!blk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready) failBound("accept");
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) blk_valid = 1'b0;
        waitDone("done");
    endtask

    task automatic checkWrites(input string tag, input logic [511:0] blk, input logic first);
        int nbad = 0;
        checkOutput({tag, "_wrcnt"}, wr_q.size(), 17);
        if (wr_q.size() == 17) begin
            for (int i = 0; i < 16; i++)
                if (wr_q[i] !== {8'h10 + 8'(i), blk[511 - 32*i -: 32]}) nbad++;
            if (wr_q[16] !== {8'h08, first ? 32'h1 : 32'h2}) nbad++;
        end
        checkOutput({tag, "_wrseq"}, nbad, 0);
    endtask

    // Called at the DONE-cycle negedge; leaves the bench at the following (IDLE) negedge.
    task automatic checkSuccess(input string tag, input logic [511:0] blk, input logic first);
        logic [255:0] expv;
        expv = sha256Compress(first ? IV : model_h, blk);
        model_h = expv;
        checkOutput({tag, "_dv"}, digest_valid, 1);
        checkOutput({tag, "_digest"}, digest, expv);
        checkOutput({tag, "_cs"}, cs, 0);
        checkOutput({tag, "_err"}, err, err_model);
        checkOutput({tag, "_lat"}, res_lat, 27 + last_b + (id_pending ? 2 : 0));
        id_pending = 1'b0;
        checkWrites(tag, blk, first);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, digest_valid, 0);
        checkOutput({tag, "_ready"}, blk_ready, 1);
        checkOutput({tag, "_dvcnt"}, dv_count, 1);
        checkOutput({tag, "_keep"}, digest, expv);
    endtask

    initial begin
        logic [511:0] abc_blk, n1_blk, n2_blk, b1, b2, rb;
        int           polls, n;

        abc_blk = {"abc", 8'h80, 416'h0, 64'h18};
        n1_blk  = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0};
        n2_blk  = {448'h0, 64'h1c0};
        blk_data = '0;
        blk_first = 1'b0;
        blk_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready", blk_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_digest", digest, 0);
        checkOutput("rst_dv", digest_valid, 0);
        checkOutput("rst_bus", {cs, we, address, write_data}, 0);
        doReset();

        $display("[TB] abc single block");
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkSuccess("abc", abc_blk, 1'b1);
        checkOutput("abc_const", digest, ABC_DIGEST);

        $display("[TB] two-block message");
        applyStimulus(n1_blk, 1'b1, 1'b0);
        checkSuccess("nist2a", n1_blk, 1'b1);
        applyStimulus(n2_blk, 1'b0, 1'b0);
        checkSuccess("nist2b", n2_blk, 1'b0);
        checkOutput("nist2_const", digest, NIST2_DIGEST);

        $display("[TB] random messages");
        for (int m = 0; m < 3; m++) begin
            n = $urandom_range(1, 2);
            for (int j = 0; j <= n; j++) begin
                rb = randBlock();
                applyStimulus(rb, j == 0, 1'b0);
                checkSuccess($sformatf("rnd%0d_%0d", m, j), rb, j == 0);
            end
        end

        $display("[TB] blk_valid held high across two blocks");
        b1 = randBlock();
        b2 = randBlock();
        applyStimulus(b1, 1'b1, 1'b1);
        checkSuccess("hold1", b1, 1'b1);
        blk_data  = b2;
        blk_first = 1'b0;
        wr_q.delete();
        dv_count = 0;
        acc_cyc = cyc;
        @(negedge clk);
        checkOutput("hold_acc_addr", address, 8'h10);
        checkOutput("hold_acc_data", write_data, b2[511:480]);
        checkOutput("hold_acc_ready", blk_ready, 0);
        blk_valid = 1'b0;
        waitDone("hold2");
        checkSuccess("hold2", b2, 1'b0);

        $display("[TB] STATUS stuck at zero");
        hold_zero = 1'b1;
        rb = randBlock();
        applyStimulus(rb, 1'b1, 1'b0);
        err_model = 1'b1;
        checkOutput("to_err", err, 1);
        checkOutput("to_ready", blk_ready, 1);
        checkOutput("to_dvcnt", dv_count, 0);
        checkOutput("to_lat", res_lat, 35 + (id_pending ? 2 : 0));
        id_pending = 1'b0;
        polls = 0;
        foreach (rd_q[i]) if (rd_q[i] == 8'h09) polls++;
        checkOutput("to_polls", polls, 1 + TO);
        checkWrites("to", rb, 1'b1);
        hold_zero = 1'b0;
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkSuccess("abc_after_to", abc_blk, 1'b1);

        $display("[TB] reset during digest readout");
        @(negedge clk);
        blk_data  = abc_blk;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        n = 0;
        while (!(cs && !we && address == 8'h24) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) failBound("rd_dig4");
        checkOutput("mid_digest_pre", digest, ABC_DIGEST);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_cs", cs, 0);
        checkOutput("mid_digest", digest, 0);
        checkOutput("mid_dv", digest_valid, 0);
        checkOutput("mid_ready", blk_ready, 1);
        checkOutput("mid_err", err, 0);
        reset = 1'b0;
        err_model = 1'b0;
`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
        id_pending = 1'b1;
`endif
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkSuccess("abc_after_rst", abc_blk, 1'b1);

`ifdef SHA256_BUS_MASTER_ID_CHECK_EN
        $display("[TB] ID check");
        doReset();
        name0 = 32'hdeadbeef;
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkOutput("id_err", err, 1);
        checkOutput("id_nowr", wr_q.size(), 0);
        checkOutput("id_nodv", dv_count, 0);
        checkOutput("id_ready", blk_ready, 1);
        checkOutput("id_lat", res_lat, 2);
        err_model = 1'b1;
        name0 = 32'h73686132;
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkOutput("id_rdn", rd_q.size() >= 2, 1);
        if (rd_q.size() >= 2) begin
            checkOutput("id_rd0", rd_q[0], 8'h00);
            checkOutput("id_rd1", rd_q[1], 8'h01);
        end
        checkSuccess("id_ok", abc_blk, 1'b1);
        applyStimulus(abc_blk, 1'b1, 1'b0);
        checkOutput("id_skip", rd_q.size() > 0 ? rd_q[0] : 8'hff, 8'h09);
        checkSuccess("id_skip", abc_blk, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
